// File: rtl/timer_periph.sv
// timer_periph: 32-bit prescaled timer/counter with compare-match level interrupt.
// Rev 1.0 - COUNT and CTRL/STATUS exposed as one 64-bit bus to the I/O read mux.
`timescale 1ns/1ps
`default_nettype none

module timer_periph #(
   parameter int T    = 32,
   parameter int PS_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [T-1:0]     wr_data,
   output logic [2*T-1:0]   dataout_bus,
   output logic             irq
);

   localparam logic [1:0] ADDR_COUNT   = 2'd0;
   localparam logic [1:0] ADDR_CTRL    = 2'd1;
   localparam logic [1:0] ADDR_COMPARE = 2'd2;

   logic [T-1:0]    count;
   logic [T-1:0]    compare;
   logic [PS_W-1:0] prescale;
   logic [PS_W-1:0] pre_cnt;
   logic            en;
   logic            auto_clr;
   logic            irq_en;
   logic            match;

   logic            wr_count;
   logic            wr_ctrl;
   logic            wr_compare;
   logic            tick;
   logic            hit;
   logic [T-1:0]    ctrl_status;

   assign wr_count   = wr_en && (wr_addr == ADDR_COUNT);
   assign wr_ctrl    = wr_en && (wr_addr == ADDR_CTRL);
   assign wr_compare = wr_en && (wr_addr == ADDR_COMPARE);

   assign tick = en && (pre_cnt == prescale);
   // Compare uses pre-edge count and compare, even if either is being written now.
   assign hit  = tick && (count == compare);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (wr_ctrl || !en || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= wr_data;
      end else if (tick) begin
         count <= (hit && auto_clr) ? '0 : count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         compare <= '1;
      end else if (wr_compare) begin
         compare <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en       <= 1'b0;
         auto_clr <= 1'b0;
         irq_en   <= 1'b0;
         prescale <= '0;
      end else if (wr_ctrl) begin
         en       <= wr_data[0];
         auto_clr <= wr_data[1];
         irq_en   <= wr_data[2];
         prescale <= wr_data[8+PS_W-1:8];
      end
   end

   // A match set by a tick wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match <= 1'b0;
      end else if (hit) begin
         match <= 1'b1;
      end else if (wr_ctrl && wr_data[3]) begin
         match <= 1'b0;
      end
   end

   always_comb begin
      ctrl_status              = '0;
      ctrl_status[0]           = en;
      ctrl_status[1]           = auto_clr;
      ctrl_status[2]           = irq_en;
      ctrl_status[3]           = match;
      ctrl_status[8+PS_W-1:8]  = prescale;
   end

   assign dataout_bus = {ctrl_status, count};
   assign irq         = match & irq_en;

endmodule

`default_nettype wire

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed self-checking bench for timer_periph.
// Rev 1.0 - one task per scenario, hand-computed expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_timer_periph;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic [63:0] dataout_bus;
   logic        irq;

   int total;
   int passed;

   timer_periph #(.T(32), .PS_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .dataout_bus (dataout_bus),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++;
      if (dataout_bus !== 64'h0 || irq !== 1'b0)
         $display("FAIL reset_init bus=%h irq=%b exp bus=0 irq=0", dataout_bus, irq);
      else passed++;
      reset = 1'b0;
      step();
      wr(2'd1, 32'h1);
      wr(2'd0, 32'h1234);
      total++;
      if (dataout_bus[31:0] !== 32'h1234)
         $display("FAIL reset_precount got %h exp %h", dataout_bus[31:0], 32'h1234);
      else passed++;
      #2 reset = 1'b1;
      #1;
      total++;
      if (dataout_bus !== 64'h0 || irq !== 1'b0)
         $display("FAIL reset_async bus=%h irq=%b exp bus=0 irq=0", dataout_bus, irq);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) step();
      total++;
      if (dataout_bus !== 64'h0)
         $display("FAIL reset_hold got %h exp %h", dataout_bus, 64'h0);
      else passed++;
   endtask

   task automatic test_free_run();
      logic [31:0] exp_c;
      wr(2'd2, 32'h1000);
      wr(2'd1, 32'h1);
      total++;
      if (dataout_bus !== {32'h1, 32'h0})
         $display("FAIL freerun_start got %h exp %h", dataout_bus, {32'h1, 32'h0});
      else passed++;
      for (int i = 1; i <= 3; i++) begin
         step();
         exp_c = i;
         total++;
         if (dataout_bus[31:0] !== exp_c)
            $display("FAIL freerun_count%0d got %h exp %h", i, dataout_bus[31:0], exp_c);
         else passed++;
      end
      wr(2'd0, 32'hFFFF_FFFE);
      step();
      total++;
      if (dataout_bus[31:0] !== 32'hFFFF_FFFF)
         $display("FAIL freerun_max got %h exp %h", dataout_bus[31:0], 32'hFFFF_FFFF);
      else passed++;
      step();
      total++;
      if (dataout_bus !== {32'h1, 32'h0})
         $display("FAIL freerun_wrap got %h exp %h", dataout_bus, {32'h1, 32'h0});
      else passed++;
   endtask

   task automatic test_prescale();
      wr(2'd1, 32'h0);
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h0301);
      total++;
      if (dataout_bus !== {32'h0301, 32'h0})
         $display("FAIL prescale_ctrl got %h exp %h", dataout_bus, {32'h0301, 32'h0});
      else passed++;
      repeat (3) step();
      total++;
      if (dataout_bus[31:0] !== 32'h0)
         $display("FAIL prescale_3cyc got %h exp %h", dataout_bus[31:0], 32'h0);
      else passed++;
      step();
      total++;
      if (dataout_bus[31:0] !== 32'h1)
         $display("FAIL prescale_4cyc got %h exp %h", dataout_bus[31:0], 32'h1);
      else passed++;
      repeat (3) step();
      total++;
      if (dataout_bus[31:0] !== 32'h1)
         $display("FAIL prescale_7cyc got %h exp %h", dataout_bus[31:0], 32'h1);
      else passed++;
      step();
      total++;
      if (dataout_bus[31:0] !== 32'h2)
         $display("FAIL prescale_8cyc got %h exp %h", dataout_bus[31:0], 32'h2);
      else passed++;
   endtask

   task automatic test_match_irq();
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h5);
      wr(2'd0, 32'h4);
      wr(2'd1, 32'h7);
      total++;
      if (dataout_bus !== {32'h7, 32'h4})
         $display("FAIL match_seq4 got %h exp %h", dataout_bus, {32'h7, 32'h4});
      else passed++;
      step();
      total++;
      if (dataout_bus !== {32'h7, 32'h5} || irq !== 1'b0)
         $display("FAIL match_seq5 bus=%h irq=%b exp bus=%h irq=0", dataout_bus, irq, {32'h7, 32'h5});
      else passed++;
      step();
      total++;
      if (dataout_bus !== {32'hF, 32'h0} || irq !== 1'b1)
         $display("FAIL match_hit bus=%h irq=%b exp bus=%h irq=1", dataout_bus, irq, {32'hF, 32'h0});
      else passed++;
   endtask

   task automatic test_w1c();
      wr(2'd1, 32'h0F);
      total++;
      if (dataout_bus !== {32'h7, 32'h1} || irq !== 1'b0)
         $display("FAIL w1c_clear bus=%h irq=%b exp bus=%h irq=0", dataout_bus, irq, {32'h7, 32'h1});
      else passed++;
      wr(2'd0, 32'h4);
      total++;
      if (dataout_bus[31:0] !== 32'h4)
         $display("FAIL w1c_load got %h exp %h", dataout_bus[31:0], 32'h4);
      else passed++;
      step();
      wr(2'd1, 32'h0F);
      total++;
      if (dataout_bus !== {32'hF, 32'h0} || irq !== 1'b1)
         $display("FAIL w1c_priority bus=%h irq=%b exp bus=%h irq=1", dataout_bus, irq, {32'hF, 32'h0});
      else passed++;
      wr(2'd1, 32'h3);
      total++;
      if (dataout_bus !== {32'hB, 32'h1} || irq !== 1'b0)
         $display("FAIL irq_mask bus=%h irq=%b exp bus=%h irq=0", dataout_bus, irq, {32'hB, 32'h1});
      else passed++;
   endtask

   task automatic test_count_collision();
      wr(2'd1, 32'h8);
      wr(2'd0, 32'h9);
      wr(2'd1, 32'h1);
      total++;
      if (dataout_bus !== {32'h1, 32'h9})
         $display("FAIL coll_setup got %h exp %h", dataout_bus, {32'h1, 32'h9});
      else passed++;
      wr(2'd0, 32'h100);
      total++;
      if (dataout_bus !== {32'h1, 32'h100})
         $display("FAIL coll_count_wr got %h exp %h", dataout_bus, {32'h1, 32'h100});
      else passed++;
      wr(2'd1, 32'h0);
      wr(2'd3, 32'hFFFF_FFFF);
      total++;
      if (dataout_bus !== {32'h0, 32'h101})
         $display("FAIL addr3_ignored got %h exp %h", dataout_bus, {32'h0, 32'h101});
      else passed++;
      // COUNT write on a tick where old count equals compare still sets match.
      wr(2'd0, 32'h5);
      wr(2'd1, 32'h1);
      wr(2'd0, 32'h20);
      total++;
      if (dataout_bus !== {32'h9, 32'h20})
         $display("FAIL coll_match got %h exp %h", dataout_bus, {32'h9, 32'h20});
      else passed++;
   endtask

   initial begin
      total   = 0;
      passed  = 0;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = 32'h0;
      #12;
      test_reset();
      test_free_run();
      test_prescale();
      test_match_irq();
      test_w1c();
      test_count_collision();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
